// File: rtl/uart_demux.sv
// ---------------------------------------------------------------------------
// uart_demux
//
// Reassembles 16-bit words {tag[3:0], payload[11:0]} from a UART byte stream.
// The high byte arrives first. Each word writes one shadow register, chosen
// by its tag. A MATCH_CTRL word (tag 7) commits every shadow register, plus
// its own decoded score and flag fields, to the outputs in a single cycle.
// The commit is marked by a one-cycle frame_valid pulse.
//
// Tags: 1 PL1_POSX, 2 PL1_POSY, 3 PL2_POSX, 4 PL2_POSY, 5 BALL_POSX,
//       6 BALL_POSY, 7 MATCH_CTRL. Tag 0 and tags 8..15 are invalid.
//       A high byte carrying an invalid tag is dropped and counted.
//
// Optional feature, controlled by the macro UART_DEMUX_TIMEOUT_EN:
//   When the macro is defined, a partial word is abandoned (and counted as
//   an error) if the low byte has not arrived within TIMEOUT_CYCLES idle
//   cycles. When the macro is undefined, the block waits for the low byte
//   indefinitely and TIMEOUT_CYCLES has no effect.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   rx_data[7:0] in   byte from the UART receiver
//   rx_valid     in   one-cycle strobe qualifying rx_data
//   pl1_posx, pl1_posy, pl2_posx, pl2_posy,
//   ball_posx, ball_posy [11:0]  out  committed positions
//   pl1_score, pl2_score [3:0]   out  committed scores
//   flag_point, end_game         out  committed match flags
//   frame_valid                  out  one-cycle pulse per MATCH_CTRL commit
//   err_cnt[7:0]                 out  saturating count of discarded bytes/words
// ---------------------------------------------------------------------------
module uart_demux #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] pl1_posx,
  output logic [11:0] pl1_posy,
  output logic [11:0] pl2_posx,
  output logic [11:0] pl2_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        frame_valid,
  output logic [7:0]  err_cnt
);

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  localparam logic [3:0] TAG_PL1_POSX  = 4'd1;
  localparam logic [3:0] TAG_PL1_POSY  = 4'd2;
  localparam logic [3:0] TAG_PL2_POSX  = 4'd3;
  localparam logic [3:0] TAG_PL2_POSY  = 4'd4;
  localparam logic [3:0] TAG_BALL_POSX = 4'd5;
  localparam logic [3:0] TAG_BALL_POSY = 4'd6;
  localparam logic [3:0] TAG_MATCH     = 4'd7;

  state_t      state;
  logic [7:0]  hi_byte;
  logic [11:0] sh_pl1_posx;
  logic [11:0] sh_pl1_posy;
  logic [11:0] sh_pl2_posx;
  logic [11:0] sh_pl2_posy;
  logic [11:0] sh_ball_posx;
  logic [11:0] sh_ball_posy;

  logic        tag_ok;
  logic [11:0] payload;
  logic [7:0]  err_next;

  // A tag is valid when it lies in 1..7, meaning it is nonzero and its MSB is clear.
  // The payload joins the latched high nibble to the low byte arriving now.
  // err_next holds the saturated increment, so err_cnt stays at 255 instead of wrapping.
  always_comb begin
    tag_ok   = (rx_data[7:4] != 4'd0) && !rx_data[7];
    payload  = {hi_byte[3:0], rx_data};
    err_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  end

`ifdef UART_DEMUX_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt;
`else
  // The parameter is kept so that both builds share one interface.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Word assembler FSM. It also owns the shadow registers, the committed
  // outputs and the error counter, so a MATCH_CTRL word updates all of
  // them on a single edge. rst wins over a coincident rx_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_HI;
      hi_byte      <= 8'd0;
      sh_pl1_posx  <= 12'd0;
      sh_pl1_posy  <= 12'd0;
      sh_pl2_posx  <= 12'd0;
      sh_pl2_posy  <= 12'd0;
      sh_ball_posx <= 12'd0;
      sh_ball_posy <= 12'd0;
      pl1_posx     <= 12'd0;
      pl1_posy     <= 12'd0;
      pl2_posx     <= 12'd0;
      pl2_posy     <= 12'd0;
      ball_posx    <= 12'd0;
      ball_posy    <= 12'd0;
      pl1_score    <= 4'd0;
      pl2_score    <= 4'd0;
      flag_point   <= 1'b0;
      end_game     <= 1'b0;
      frame_valid  <= 1'b0;
      err_cnt      <= 8'd0;
`ifdef UART_DEMUX_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      case (state)
        WAIT_HI: begin
          if (rx_valid) begin
            if (tag_ok) begin
              hi_byte <= rx_data;
              state   <= WAIT_LO;
`ifdef UART_DEMUX_TIMEOUT_EN
              to_cnt  <= '0;
`endif
            end else begin
              err_cnt <= err_next;
            end
          end
        end
        WAIT_LO: begin
          if (rx_valid) begin
            state <= WAIT_HI;
            case (hi_byte[7:4])
              TAG_PL1_POSX:  sh_pl1_posx  <= payload;
              TAG_PL1_POSY:  sh_pl1_posy  <= payload;
              TAG_PL2_POSX:  sh_pl2_posx  <= payload;
              TAG_PL2_POSY:  sh_pl2_posy  <= payload;
              TAG_BALL_POSX: sh_ball_posx <= payload;
              TAG_BALL_POSY: sh_ball_posy <= payload;
              TAG_MATCH: begin
                pl1_posx    <= sh_pl1_posx;
                pl1_posy    <= sh_pl1_posy;
                pl2_posx    <= sh_pl2_posx;
                pl2_posy    <= sh_pl2_posy;
                ball_posx   <= sh_ball_posx;
                ball_posy   <= sh_ball_posy;
                end_game    <= payload[9];
                flag_point  <= payload[8];
                pl2_score   <= payload[7:4];
                pl1_score   <= payload[3:0];
                frame_valid <= 1'b1;
              end
              default: ;
            endcase
          end
`ifdef UART_DEMUX_TIMEOUT_EN
          // The timeout fires on the idle cycle that would bring the count
          // to TIMEOUT_CYCLES. A byte arriving on that cycle still counts
          // as the low byte, because the rx_valid branch above takes precedence.
          else if (to_cnt == CNT_LAST) begin
            state   <= WAIT_HI;
            err_cnt <= err_next;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= WAIT_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_demux.sv
// ---------------------------------------------------------------------------
// tb_uart_demux
//
// Testbench for uart_demux. Most checks come from a table of byte pairs,
// each with the full output state expected one cycle after the low byte.
// Hand-written sequences follow, covering reset in mid-word, err_cnt
// saturation, and the inter-byte timeout (taken from the build's
// UART_DEMUX_TIMEOUT_EN setting).
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_uart_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] pl1_posx, pl1_posy, pl2_posx, pl2_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, frame_valid;
  logic [7:0]  err_cnt;

  int tests    = 0;
  int failures = 0;

  uart_demux #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .pl1_posx    (pl1_posx),
    .pl1_posy    (pl1_posy),
    .pl2_posx    (pl2_posx),
    .pl2_posy    (pl2_posy),
    .ball_posx   (ball_posx),
    .ball_posy   (ball_posy),
    .pl1_score   (pl1_score),
    .pl2_score   (pl2_score),
    .flag_point  (flag_point),
    .end_game    (end_game),
    .frame_valid (frame_valid),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] p1x, p1y, p2x, p2y, bx, by;
    logic [3:0]  s1, s2;
    logic        fp, eg, fv;
    logic [7:0]  err;
  } outs_t;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    outs_t      exp;
  } vec_t;

  function automatic outs_t mk(
    input logic [11:0] p1x, p1y, p2x, p2y, bx, by,
    input logic [3:0] s1, s2, input logic fp, eg, fv, input logic [7:0] err);
    outs_t o;
    o.p1x = p1x; o.p1y = p1y; o.p2x = p2x; o.p2y = p2y; o.bx = bx; o.by = by;
    o.s1 = s1; o.s2 = s2; o.fp = fp; o.eg = eg; o.fv = fv; o.err = err;
    return o;
  endfunction

  task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
    end
  endtask

  // Compares every output against one expected record.
  task automatic checkOutput(input outs_t e, input string name);
    cmp({name, " pl1_posx"},    32'(pl1_posx),    32'(e.p1x));
    cmp({name, " pl1_posy"},    32'(pl1_posy),    32'(e.p1y));
    cmp({name, " pl2_posx"},    32'(pl2_posx),    32'(e.p2x));
    cmp({name, " pl2_posy"},    32'(pl2_posy),    32'(e.p2y));
    cmp({name, " ball_posx"},   32'(ball_posx),   32'(e.bx));
    cmp({name, " ball_posy"},   32'(ball_posy),   32'(e.by));
    cmp({name, " pl1_score"},   32'(pl1_score),   32'(e.s1));
    cmp({name, " pl2_score"},   32'(pl2_score),   32'(e.s2));
    cmp({name, " flag_point"},  32'(flag_point),  32'(e.fp));
    cmp({name, " end_game"},    32'(end_game),    32'(e.eg));
    cmp({name, " frame_valid"}, 32'(frame_valid), 32'(e.fv));
    cmp({name, " err_cnt"},     32'(err_cnt),     32'(e.err));
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Sends two bytes back to back. Returns on the negedge after the low
  // byte's edge, where the committed values are first visible.
  task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] lo);
    sendByte(hi);
    sendByte(lo);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t  vecs[15];
  outs_t zero;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = '{8'h11, 8'h23, mk(0,     0,     0,     0,     0,     0,     0,   0,   0, 0, 0, 0)};
    vecs[1]  = '{8'h70, 8'h00, mk(12'h123, 0,   0,     0,     0,     0,     0,   0,   0, 0, 1, 0)};
    vecs[2]  = '{8'h72, 8'h53, mk(12'h123, 0,   0,     0,     0,     0,     3,   5,   0, 1, 1, 0)};
    vecs[3]  = '{8'h50, 8'h40, mk(12'h123, 0,   0,     0,     0,     0,     3,   5,   0, 1, 0, 0)};
    vecs[4]  = '{8'h70, 8'h00, mk(12'h123, 0,   0,     0,     12'h040, 0,   0,   0,   0, 0, 1, 0)};
    vecs[5]  = '{8'h80, 8'h00, mk(12'h123, 0,   0,     0,     12'h040, 0,   0,   0,   0, 0, 0, 2)};
    vecs[6]  = '{8'h2A, 8'hBC, mk(12'h123, 0,   0,     0,     12'h040, 0,   0,   0,   0, 0, 0, 2)};
    vecs[7]  = '{8'h33, 8'h45, mk(12'h123, 0,   0,     0,     12'h040, 0,   0,   0,   0, 0, 0, 2)};
    vecs[8]  = '{8'h4F, 8'hFF, mk(12'h123, 0,   0,     0,     12'h040, 0,   0,   0,   0, 0, 0, 2)};
    vecs[9]  = '{8'h6E, 8'hEE, mk(12'h123, 0,   0,     0,     12'h040, 0,   0,   0,   0, 0, 0, 2)};
    vecs[10] = '{8'h7F, 8'hFF, mk(12'h123, 12'hABC, 12'h345, 12'hFFF, 12'h040, 12'hEEE, 4'hF, 4'hF, 1, 1, 1, 2)};
    vecs[11] = '{8'h71, 8'h00, mk(12'h123, 12'hABC, 12'h345, 12'hFFF, 12'h040, 12'hEEE, 0, 0, 1, 0, 1, 2)};
    vecs[12] = '{8'h7C, 8'h00, mk(12'h123, 12'hABC, 12'h345, 12'hFFF, 12'h040, 12'hEEE, 0, 0, 0, 0, 1, 2)};
    vecs[13] = '{8'h90, 8'h00, mk(12'h123, 12'hABC, 12'h345, 12'hFFF, 12'h040, 12'hEEE, 0, 0, 0, 0, 0, 4)};
    vecs[14] = '{8'hF0, 8'h00, mk(12'h123, 12'hABC, 12'h345, 12'hFFF, 12'h040, 12'hEEE, 0, 0, 0, 0, 0, 6)};

    doReset();
    @(negedge clk);
    checkOutput(zero, "reset");

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].hi, vecs[i].lo);
      checkOutput(vecs[i].exp, $sformatf("vec%0d", i));
      if (vecs[i].exp.fv) begin
        @(negedge clk);
        cmp($sformatf("vec%0d frame_valid drop", i), 32'(frame_valid), 32'd0);
      end
    end

    // err_cnt saturation: 300 invalid bytes, sent back to back.
    for (int i = 0; i < 300; i++) sendByte(8'h00);
    idle(1);
    cmp("err_cnt saturated", 32'(err_cnt), 32'd255);
    cmp("saturation keeps outputs", 32'(pl1_posx), 32'h123);
    sendByte(8'h0F);
    idle(1);
    cmp("err_cnt no wrap", 32'(err_cnt), 32'd255);

    // Reset lands while a word is half received, and a valid byte arrives
    // on the same edge as reset. Neither byte may stick.
    doReset();
    sendByte(8'h11);
    @(negedge clk);
    rst      = 1'b1;
    rx_data  = 8'h23;
    rx_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    checkOutput(zero, "mid-word reset");
    applyStimulus(8'h23, 8'h00);
    applyStimulus(8'h70, 8'h00);
    checkOutput(mk(0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "after reset");

`ifdef UART_DEMUX_TIMEOUT_EN
    // The 16th idle cycle abandons the partial word, so 0x61 starts a new word.
    doReset();
    sendByte(8'h31);
    idle(16);
    applyStimulus(8'h61, 8'h00);
    applyStimulus(8'h70, 8'h00);
    checkOutput(mk(0, 0, 0, 0, 0, 12'h100, 0, 0, 0, 0, 1, 1), "timeout");
    // A low byte arriving exactly on the deadline cycle is still accepted.
    sendByte(8'h31);
    idle(15);
    sendByte(8'h22);
    idle(1);
    applyStimulus(8'h70, 8'h00);
    checkOutput(mk(0, 0, 12'h122, 0, 0, 12'h100, 0, 0, 0, 0, 1, 1), "deadline byte");
`else
    // Without the timeout, the low byte is accepted after any gap.
    doReset();
    sendByte(8'h31);
    idle(40);
    sendByte(8'h61);
    idle(1);
    applyStimulus(8'h70, 8'h00);
    checkOutput(mk(0, 0, 12'h161, 0, 0, 0, 0, 0, 0, 0, 1, 0), "no timeout");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
